// File: rtl/mult_share_arbiter.sv
// Round-robin front end that shares one external fixed-latency 32x32 multiplier
// among NUM_REQ clients and returns ID-tagged products through a show-ahead FIFO.
module mult_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MUL_LAT    = 2,
    parameter int FIFO_DEPTH = 8,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic                  mul_start,
    output logic signed [31:0]    mul_a,
    output logic signed [31:0]    mul_b,
    input  logic signed [31:0]    mul_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic signed [31:0]    rsp_result,
    output logic                  busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = ID_W + 32;

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               mul_start_q, mul_start_d;
    logic signed [31:0] mul_a_q, mul_a_d;
    logic signed [31:0] mul_b_q, mul_b_d;
    logic [MUL_LAT:0]   tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]    tag_id_q [MUL_LAT+1];
    logic [ID_W-1:0]    tag_id_d [MUL_LAT+1];
    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;

    logic               grant_vld;
    logic [ID_W-1:0]    grant_id;
    logic signed [31:0] sel_a, sel_b;
    logic               credit_ok;
    logic               hs;
    logic               wr_en;
    logic               pop;
    logic [ENT_W-1:0]   head;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        logic [ID_W:0] slot;
        grant_vld = 1'b0;
        grant_id  = '0;
        slot      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (slot >= (ID_W+1)'(NUM_REQ)) slot = slot - (ID_W+1)'(NUM_REQ);
            if (!grant_vld && req_valid[slot[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = slot[ID_W-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                sel_a = req_a[32*k +: 32];
                sel_b = req_b[32*k +: 32];
            end
        end
    end

    // Every accepted request owns a FIFO slot until popped, so writes can never overflow.
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < (CNT_W+1)'(FIFO_DEPTH);
    assign hs        = grant_vld & credit_ok & ~rst;
    assign req_ready = hs ? (NUM_REQ'(1) << grant_id) : '0;

    assign wr_en     = tag_vld_q[MUL_LAT];
    assign rsp_valid = (fifo_cnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs) rr_ptr_d = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);

        mul_start_d = hs;
        mul_a_d     = hs ? sel_a : mul_a_q;
        mul_b_d     = hs ? sel_b : mul_b_q;

        // Tag stage MUL_LAT lines up with the cycle mul_result carries this request's product.
        tag_vld_d   = {tag_vld_q[MUL_LAT-1:0], hs};
        tag_id_d[0] = grant_id;
        for (int s = 1; s <= MUL_LAT; s++) tag_id_d[s] = tag_id_q[s-1];

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = {tag_id_q[MUL_LAT], mul_result};
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);

        fifo_cnt_d = fifo_cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
        inflight_d = inflight_q + CNT_W'(hs) - CNT_W'(wr_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            tag_vld_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            inflight_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_vld_q   <= tag_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            inflight_q  <= inflight_d;
        end
    end

    // Payload storage needs no reset; the valid bits and counters qualify it.
    always_ff @(posedge clk) begin
        tag_id_q <= tag_id_d;
        mem_q    <= mem_d;
    end

    assign head       = mem_q[rd_ptr_q];
    assign rsp_id     = rsp_valid ? head[ENT_W-1:32] : '0;
    assign rsp_result = rsp_valid ? $signed(head[31:0]) : '0;
    assign busy       = (inflight_q != '0) | (fifo_cnt_q != '0);
    assign mul_start  = mul_start_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Shares one fixed-latency signed 32x32 multiplier between NUM_REQ requesters. Round-robin arbitration selects one request per cycle and issues it to the external multiplier port. Each result is tagged with its requester ID and buffered in an internal response FIFO with valid/ready backpressure. The block sits between client logic and the multiplier datapath; the bench drives mul_result from the DPI-C multiply model delayed by MUL_LAT.

Parameters:
NUM_REQ, 4, number of requesters (2..16); ID_W = $clog2(NUM_REQ), derived localparam
MUL_LAT, 2, cycles from mul_start sampled to mul_result valid (>=1)
FIFO_DEPTH, 8, response FIFO entries; one-per-cycle throughput requires FIFO_DEPTH >= MUL_LAT+3

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_a  in  32*NUM_REQ  signed operand A, requester i at [32*i +: 32]
req_b  in  32*NUM_REQ  signed operand B, same packing
mul_start  out  1  issue strobe to the multiplier, registered
mul_a  out  32  signed operand to the multiplier, registered
mul_b  out  32  signed operand to the multiplier, registered
mul_result  in  32  signed product, valid exactly MUL_LAT cycles after the mul_start cycle
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer accept
rsp_id  out  ID_W  requester index of the response
rsp_result  out  32  signed product, low 32 bits
busy  out  1  any operation in flight or in the FIFO

Behaviour:
- Reset (rst=1 at posedge) sets: req_ready=0, mul_start=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, RR pointer=0, FIFO empty, all tag-pipe valid bits cleared, in-flight count=0.
- Credit:
  - inflight = accepted requests not yet written into the FIFO.
  - Issue is allowed only when inflight + fifo_count < FIFO_DEPTH.
  - A FIFO pop frees its credit on the next cycle, never the same cycle.
  - FIFO overflow is therefore impossible. Bench asserts that a write never occurs when the FIFO is full.
- Arbitration:
  - Combinational round-robin over req_valid, starting at the RR pointer.
  - When issue is allowed, exactly one req_ready bit is high, for the granted requester g. Otherwise all bits are 0.
  - A handshake is req_valid[g] & req_ready[g] at posedge. After it, the RR pointer becomes (g+1) mod NUM_REQ. Without a handshake the pointer holds.
  - Requesters must not make req_valid depend on req_ready.
  - Operands must be held stable while req_valid is high and the request is unaccepted.
- Issue: a handshake at cycle t drives mul_start=1 in cycle t+1, with mul_a/mul_b holding that request's operands. Otherwise mul_start=0 and mul_a/mul_b hold their last values.
- Tag pipe: MUL_LAT+1 stages carrying {valid, id}, aligned so the tag meets mul_result in cycle t+1+MUL_LAT.
- FIFO write: a valid tag writes {id, mul_result} at the end of cycle t+1+MUL_LAT.
- Response: the FIFO is show-ahead, so rsp_valid rises in cycle t+MUL_LAT+2.
  - Total accept-to-response latency is MUL_LAT+2 cycles when the FIFO is empty.
  - Pop occurs on rsp_valid & rsp_ready.
  - rsp_id/rsp_result stay stable while rsp_valid=1 & rsp_ready=0.
- Ordering: responses leave strictly in issue order.
- Arithmetic: no arithmetic in the block. mul_result is passed through unchanged; overflow wrap is the multiplier's (low 32 bits).
- FIFO write and pop in the same cycle: both happen and the count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- busy = (inflight != 0) | (fifo_count != 0).
- Reset mid-operation: in-flight tags and FIFO contents are discarded. mul_result values arriving after reset are ignored. No response is emitted for pre-reset requests.

Test Plan:
- Single request: req 2, a=10, b=20, accepted at cycle 5 -> mul_start=1 with mul_a=10, mul_b=20 in cycle 6; model returns 200 in cycle 8; rsp_valid=1, rsp_id=2, rsp_result=200 in cycle 9; busy low from cycle 10 after pop.
- All 4 requesters continuously valid, rsp_ready=1 -> grants 0,1,2,3,0,... at one per cycle, no bubbles; rsp_id sequence matches; each rsp_result = a*b.
- Backpressure: rsp_ready=0 with requesters valid -> exactly 8 accepts, then req_ready=0 and busy=1. Raise rsp_ready -> 8 responses drain in order, then issuing resumes.
- Fairness: req0 always valid, req3 valid from cycle 10 -> req3 granted within 4 cycles; grants alternate 0,3,0,3 while both are valid.
- Wrap/sign: a=32'h0001_0000, b=32'h0001_0000 -> rsp_result=0; a=-3, b=7 -> rsp_result=-21; a=32'h7FFF_FFFF, b=2 -> 32'hFFFF_FFFE.
- Reset mid-operation: 3 requests in flight, rst=1 for 1 cycle -> following cycles show rsp_valid=0, busy=0, no response from late mul_result; next request is granted starting at requester 0.
